rom_fetch_responder: RTL and testbench
======================================

Name: rom_fetch_responder

Overview:
- ROM-side responder for the instruction cache's refill interface.
- Services the cache's fetch_req by reading one byte at {pbr, pc} from the game ROM bus, then returns it on instr_data with a one-clock romrdy pulse.
- Honours ROM bus ownership (ron) and the clock-speed-dependent ROM wait count selected by clsr.
- Sits between the cache/instruction-fetch logic and the external ROM pins.

Parameters:
- WAIT_LO, 3: ROM wait cycles when clsr=0; legal range 1..15.
- WAIT_HI, 5: ROM wait cycles when clsr=1; legal range 1..15.
- TIMEOUT, 255: cycles of fetch_req held while ron=0 before rom_timeout asserts. Only used with ROM_TIMEOUT_EN.

Ports:
- clk  in  1  main clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  refill request from the cache; level-sensitive.
- pc  in  16  program counter (byte address within bank).
- pbr  in  8  program bank register.
- ron  in  1  1 = this chip owns the ROM bus.
- clsr  in  1  clock speed select; picks WAIT_HI (1) or WAIT_LO (0).
- rom_data  in  8  ROM data bus.
- rom_addr  out  24  ROM address; registered.
- rom_rd_n  out  1  ROM read strobe, active low; registered.
- romrdy  out  1  one-clock pulse: instr_data valid, cache may write.
- instr_data  out  8  fetched byte; holds last value between pulses.
- busy  out  1  high in any state other than IDLE.
- rom_timeout  out  1  sticky timeout flag. Tied 0 when ROM_TIMEOUT_EN is off.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rom_addr=0, rom_rd_n=1, romrdy=0, instr_data=0, busy=0, rom_timeout=0.
  - Counters cleared.
- States: IDLE, SETUP, WAIT, DONE, GAP.
- IDLE:
  - On an edge with fetch_req=1 and ron=1: capture {pbr,pc} into rom_addr, drive rom_rd_n=0.
  - Load wait counter with clsr ? WAIT_HI : WAIT_LO (clsr sampled here only), then go to SETUP.
  - If fetch_req=1 and ron=0: stay in IDLE.
- SETUP: one cycle, then go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - When the counter reaches 1: register rom_data into instr_data, drive rom_rd_n=1, go to DONE.
- DONE:
  - romrdy=1 for exactly this cycle.
  - Leave on the next edge to GAP.
- GAP:
  - One idle cycle with romrdy=0 so the requester can advance pc before fetch_req is re-sampled.
  - Then go to IDLE.
- Latency: with fetch_req first sampled at edge k, romrdy rises at edge k+N+1 and falls at k+N+2, where N is the selected wait count.
- Back-to-back requests: minimum spacing between romrdy pulses is N+3 clocks.
- ron falls in SETUP or WAIT:
  - Abort: rom_rd_n=1 on the same edge, no romrdy, instr_data unchanged, go to IDLE.
  - Retry from scratch once ron=1.
- Address change mid-fetch: if {pbr,pc} differs from rom_addr at the WAIT→DONE edge (e.g. a branch):
  - Suppress romrdy and instr_data update; go to GAP; then re-fetch at the new address.
- fetch_req drops mid-fetch: the access completes and romrdy still pulses. Harmless, because the cache write enable is gated by its own range check.
- rom_addr holds its last value when not accessing.
- Reset asserted mid-access: immediate return to reset values, rom_rd_n=1 asynchronously.
- pc wrap: 0xFFFF→0x0000 is the requester's concern. This block adds no bank carry; rom_addr is exactly {pbr,pc}.

Optional Feature:
- Macro: ROM_TIMEOUT_EN.
- Defined:
  - A 16-bit saturating counter increments on each clock with fetch_req=1 and ron=0 in IDLE.
  - The counter clears when ron=1 or fetch_req=0.
  - When the counter reaches TIMEOUT, rom_timeout sets; it is sticky until rst_n or the next completed romrdy.
- Undefined: counter absent; rom_timeout is constant 0.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0, then 1, with fetch_req=0.
  - Response: rom_rd_n=1, romrdy=0, instr_data=0x00, busy=0 for 20 clocks.
- Single fetch, slow path:
  - Stimulus: clsr=0, ron=1, pbr=0x01, pc=0x8000, rom_data=0xA5, fetch_req at edge 10.
  - Response: rom_addr=0x018000; rom_rd_n low edges 10–13; romrdy high only after edge 14; instr_data=0xA5.
- clsr=1:
  - Stimulus: same request as above.
  - Response: romrdy after edge 16. Then pc=0x8001, data 0x3C: second romrdy exactly 8 clocks after the first.
- ron drop:
  - Stimulus: ron=0 at edge 12 of a fetch, restored at 20.
  - Response: rom_rd_n=1 at 12, no romrdy until a fresh access; romrdy at 24 (WAIT_LO).
- Branch mid-fetch:
  - Stimulus: pc 0x8000→0x9000 during WAIT.
  - Response: no romrdy for 0x8000; next access rom_addr=0x019000 and delivers its byte.
- ROM_TIMEOUT_EN:
  - Stimulus: TIMEOUT=8, fetch_req=1, ron=0.
  - Response: rom_timeout=1 after 8 clocks; stays set; clears after ron=1 and the next romrdy.

Source files
------------

// File: rtl/rom_fetch_responder.sv
// rtl/rom_fetch_responder.sv - ROM-side byte fetch responder for the instruction cache refill port.
// Optional sticky fetch timeout is built when ROM_TIMEOUT_EN is defined.

module rom_fetch_responder #(
   parameter int WAIT_LO = 3,
   parameter int WAIT_HI = 5,
   parameter int TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_fetch_req,
   input  logic [15:0] i_pc,
   input  logic [7:0]  i_pbr,
   input  logic        i_ron,
   input  logic        i_clsr,
   input  logic [7:0]  i_rom_data,
   output logic [23:0] o_rom_addr,
   output logic        o_rom_rd_n,
   output logic        o_romrdy,
   output logic [7:0]  o_instr_data,
   output logic        o_busy,
   output logic        o_rom_timeout
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_DONE, S_GAP} state_t;

   localparam logic [3:0] LP_WAIT_LO = 4'(WAIT_LO);
   localparam logic [3:0] LP_WAIT_HI = 4'(WAIT_HI);

   // Out-of-range parameters leave a marker scope in the elaborated hierarchy.
   if (WAIT_LO < 1 || WAIT_LO > 15 || WAIT_HI < 1 || WAIT_HI > 15 ||
       TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_range_violation
   end

   state_t      r_state, w_state_nx;
   logic [3:0]  r_cnt, w_cnt_nx;
   logic [23:0] r_addr, w_addr_nx;
   logic        r_rd_n, w_rd_n_nx;
   logic [7:0]  r_data, w_data_nx;
   logic        r_rdy, w_rdy_nx;
   logic [23:0] w_cur_addr;
   logic        w_start;

   assign w_cur_addr = {i_pbr, i_pc};
   assign w_start    = i_fetch_req & i_ron;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= 24'd0;
         r_rd_n  <= 1'b1;
         r_data  <= 8'd0;
         r_rdy   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_addr  <= w_addr_nx;
         r_rd_n  <= w_rd_n_nx;
         r_data  <= w_data_nx;
         r_rdy   <= w_rdy_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_addr_nx  = r_addr;
      w_rd_n_nx  = r_rd_n;
      w_data_nx  = r_data;
      w_rdy_nx   = 1'b0;
      case (r_state)
         // GAP's closing edge doubles as the re-sample point, giving N+3 pulse spacing.
         S_IDLE, S_GAP: begin
            if (w_start) begin
               w_addr_nx  = w_cur_addr;
               w_rd_n_nx  = 1'b0;
               w_cnt_nx   = i_clsr ? LP_WAIT_HI : LP_WAIT_LO;
               w_state_nx = S_SETUP;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_SETUP: begin
            if (!i_ron) begin
               w_rd_n_nx  = 1'b1;
               w_state_nx = S_IDLE;
            end else begin
               w_state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!i_ron) begin
               w_rd_n_nx  = 1'b1;
               w_state_nx = S_IDLE;
            end else if (r_cnt <= 4'd1) begin
               w_rd_n_nx = 1'b1;
               // A branch during the access makes this byte stale: drop it and refetch.
               if (w_cur_addr == r_addr) begin
                  w_data_nx  = i_rom_data;
                  w_rdy_nx   = 1'b1;
                  w_state_nx = S_DONE;
               end else begin
                  w_state_nx = S_GAP;
               end
            end else begin
               w_cnt_nx = r_cnt - 4'd1;
            end
         end
         S_DONE:  w_state_nx = S_GAP;
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign o_rom_addr   = r_addr;
   assign o_rom_rd_n   = r_rd_n;
   assign o_romrdy     = r_rdy;
   assign o_instr_data = r_data;
   assign o_busy       = (r_state != S_IDLE);

`ifdef ROM_TIMEOUT_EN
   localparam logic [16:0] LP_TIMEOUT = 17'(TIMEOUT);

   logic [15:0] r_to_cnt;
   logic        r_timeout;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_to_cnt  <= 16'd0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == S_IDLE && i_fetch_req && !i_ron) begin
            if (r_to_cnt != 16'hFFFF) begin
               r_to_cnt <= r_to_cnt + 16'd1;
            end
            if (({1'b0, r_to_cnt} + 17'd1) >= LP_TIMEOUT) begin
               r_timeout <= 1'b1;
            end
         end else begin
            r_to_cnt <= 16'd0;
         end
         if (r_state == S_DONE) begin
            r_timeout <= 1'b0;
         end
      end
   end

   assign o_rom_timeout = r_timeout;
`else
   assign o_rom_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rom_fetch_responder.sv
// tb/tb_rom_fetch_responder.sv - self-checking scoreboard bench for rom_fetch_responder.

module tb_rom_fetch_responder;

   typedef struct packed {
      logic [7:0]  data;
      logic [23:0] addr;
      logic [31:0] cyc;
   } ev_t;

   logic        clk;
   logic        rst_n;
   logic        fetch_req;
   logic [15:0] pc;
   logic [7:0]  pbr;
   logic        ron;
   logic        clsr;
   logic [7:0]  rom_data;
   logic [23:0] o_rom_addr;
   logic        o_rom_rd_n;
   logic        o_romrdy;
   logic [7:0]  o_instr_data;
   logic        o_busy;
   logic        o_rom_timeout;

   logic [31:0] cyc = 0;
   int          total = 0;
   int          bad = 0;
   ev_t         exp_q[$];
   ev_t         obs_q[$];

   rom_fetch_responder #(.WAIT_LO(3), .WAIT_HI(5), .TIMEOUT(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_fetch_req  (fetch_req),
      .i_pc         (pc),
      .i_pbr        (pbr),
      .i_ron        (ron),
      .i_clsr       (clsr),
      .i_rom_data   (rom_data),
      .o_rom_addr   (o_rom_addr),
      .o_rom_rd_n   (o_rom_rd_n),
      .o_romrdy     (o_romrdy),
      .o_instr_data (o_instr_data),
      .o_busy       (o_busy),
      .o_rom_timeout(o_rom_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && o_romrdy === 1'b1) begin
         obs_q.push_back({o_instr_data, o_rom_addr, cyc});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cyc(input logic [31:0] target);
      while (cyc < target) step;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; fetch_req = 1'b0; pc = 16'h0; pbr = 8'h0;
      ron = 1'b0; clsr = 1'b0; rom_data = 8'h0;
      repeat (3) step;
      total++;
      if ({o_rom_rd_n, o_romrdy, o_instr_data, o_busy, o_rom_addr, o_rom_timeout} !== {1'b1, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0}) begin
         bad++;
         $display("FAIL reset_held rd_n=%b rdy=%b data=%h busy=%b addr=%h to=%b, want 1 0 00 0 000000 0",
                  o_rom_rd_n, o_romrdy, o_instr_data, o_busy, o_rom_addr, o_rom_timeout);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step;
         total++;
         if ({o_rom_rd_n, o_romrdy, o_instr_data, o_busy, o_rom_timeout} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL idle_after_reset cycle %0d rd_n=%b rdy=%b data=%h busy=%b to=%b, want 1 0 00 0 0",
                     i, o_rom_rd_n, o_romrdy, o_instr_data, o_busy, o_rom_timeout);
         end
      end
   endtask

   task automatic drain(input string name);
      ev_t e, o;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL %s missing_romrdy got none, want data=%h addr=%h cyc=%0d", name, e.data, e.addr, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               bad++;
               $display("FAIL %s romrdy got data=%h addr=%h cyc=%0d, want data=%h addr=%h cyc=%0d",
                        name, o.data, o.addr, o.cyc, e.data, e.addr, e.cyc);
            end
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++;
         $display("FAIL %s extra_romrdy got %0d extra pulses, want 0", name, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_slow_fetch;
      logic [31:0] k;
      clsr = 1'b0; ron = 1'b1; pbr = 8'h01; pc = 16'h8000; rom_data = 8'hA5;
      step;
      k = cyc + 1; fetch_req = 1'b1;
      exp_q.push_back({8'hA5, 24'h018000, k + 4});
      step;
      fetch_req = 1'b0;
      total++;
      if ({o_rom_addr, o_busy} !== {24'h018000, 1'b1}) begin
         bad++;
         $display("FAIL slow_capture addr=%h busy=%b, want 018000 1", o_rom_addr, o_busy);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({o_rom_rd_n, o_romrdy} !== 2'b00) begin
            bad++;
            $display("FAIL slow_rd_low edge k+%0d rd_n=%b rdy=%b, want 0 0", i, o_rom_rd_n, o_romrdy);
         end
         step;
      end
      total++;
      if ({o_rom_rd_n, o_romrdy, o_instr_data} !== {1'b1, 1'b1, 8'hA5}) begin
         bad++;
         $display("FAIL slow_done rd_n=%b rdy=%b data=%h, want 1 1 a5", o_rom_rd_n, o_romrdy, o_instr_data);
      end
      step;
      total++;
      if ({o_romrdy, o_busy} !== 2'b01) begin
         bad++;
         $display("FAIL slow_gap rdy=%b busy=%b, want 0 1", o_romrdy, o_busy);
      end
      step;
      drain("slow");
   endtask

   task automatic test_clsr_back_to_back;
      logic [31:0] k;
      clsr = 1'b1; ron = 1'b1; pbr = 8'h01; pc = 16'h8000; rom_data = 8'hA5;
      step;
      k = cyc + 1; fetch_req = 1'b1;
      exp_q.push_back({8'hA5, 24'h018000, k + 6});
      exp_q.push_back({8'h3C, 24'h018001, k + 14});
      wait_cyc(k + 6);
      pc = 16'h8001; rom_data = 8'h3C;
      wait_cyc(k + 14);
      fetch_req = 1'b0;
      step; step; step;
      total++;
      if (o_busy !== 1'b0) begin
         bad++;
         $display("FAIL clsr_return_idle busy=%b, want 0", o_busy);
      end
      drain("clsr");
   endtask

   task automatic test_ron_drop;
      logic [31:0] k;
      clsr = 1'b0; ron = 1'b1; pbr = 8'h01; pc = 16'h8000; rom_data = 8'h5A;
      step;
      k = cyc + 1; fetch_req = 1'b1;
      wait_cyc(k + 1);
      ron = 1'b0;
      step;
      total++;
      if ({o_rom_rd_n, o_romrdy, o_busy, o_instr_data} !== {1'b1, 1'b0, 1'b0, 8'h3C}) begin
         bad++;
         $display("FAIL ron_abort rd_n=%b rdy=%b busy=%b data=%h, want 1 0 0 3c",
                  o_rom_rd_n, o_romrdy, o_busy, o_instr_data);
      end
      wait_cyc(k + 9);
      total++;
      if ({o_rom_rd_n, o_busy} !== 2'b10) begin
         bad++;
         $display("FAIL ron_held_idle rd_n=%b busy=%b, want 1 0", o_rom_rd_n, o_busy);
      end
      ron = 1'b1;
      exp_q.push_back({8'h5A, 24'h018000, k + 14});
      wait_cyc(k + 14);
      fetch_req = 1'b0;
      step;
      drain("ron_drop");
   endtask

   task automatic test_branch;
      logic [31:0] k;
      clsr = 1'b0; ron = 1'b1; pbr = 8'h01; pc = 16'h8000; rom_data = 8'h11;
      step;
      k = cyc + 1; fetch_req = 1'b1;
      wait_cyc(k + 2);
      pc = 16'h9000; rom_data = 8'h22;
      wait_cyc(k + 4);
      total++;
      if ({o_romrdy, o_rom_rd_n, o_busy, o_instr_data} !== {1'b0, 1'b1, 1'b1, 8'h5A}) begin
         bad++;
         $display("FAIL branch_suppress rdy=%b rd_n=%b busy=%b data=%h, want 0 1 1 5a",
                  o_romrdy, o_rom_rd_n, o_busy, o_instr_data);
      end
      step;
      total++;
      if ({o_rom_addr, o_rom_rd_n} !== {24'h019000, 1'b0}) begin
         bad++;
         $display("FAIL branch_refetch addr=%h rd_n=%b, want 019000 0", o_rom_addr, o_rom_rd_n);
      end
      exp_q.push_back({8'h22, 24'h019000, k + 9});
      wait_cyc(k + 9);
      fetch_req = 1'b0;
      step;
      drain("branch");
   endtask

   task automatic test_back_to_back;
      logic [31:0] k, t_next;
      clsr = 1'b0; ron = 1'b1; pbr = 8'h02; pc = 16'hA000; rom_data = 8'($urandom);
      step;
      k = cyc + 1; fetch_req = 1'b1;
      t_next = k + 4;
      exp_q.push_back({rom_data, pbr, pc, t_next});
      for (int i = 0; i < 6; i++) begin
         wait_cyc(t_next);
         total++;
         if (o_romrdy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_pulse_%0d rdy=%b at cyc %0d, want 1", i, o_romrdy, cyc);
         end
         if (i == 5) begin
            fetch_req = 1'b0;
         end else begin
            pc = pc + 16'd1;
            rom_data = 8'($urandom);
            clsr = 1'($urandom);
            t_next = t_next + (clsr ? 32'd8 : 32'd6);
            exp_q.push_back({rom_data, pbr, pc, t_next});
         end
      end
      step; step; step;
      drain("b2b");
   endtask

   task automatic test_timeout;
      logic [31:0] k;
      clsr = 1'b0; pbr = 8'h03; pc = 16'h0100; rom_data = 8'h77;
      ron = 1'b0; fetch_req = 1'b1;
`ifdef ROM_TIMEOUT_EN
      repeat (7) step;
      total++;
      if ({o_rom_timeout, o_busy} !== 2'b00) begin
         bad++;
         $display("FAIL timeout_early to=%b busy=%b after 7 clocks, want 0 0", o_rom_timeout, o_busy);
      end
      step;
      total++;
      if (o_rom_timeout !== 1'b1) begin
         bad++;
         $display("FAIL timeout_set to=%b after 8 clocks, want 1", o_rom_timeout);
      end
      repeat (5) step;
      fetch_req = 1'b0;
      step; step;
      total++;
      if (o_rom_timeout !== 1'b1) begin
         bad++;
         $display("FAIL timeout_sticky to=%b, want 1", o_rom_timeout);
      end
      ron = 1'b1; fetch_req = 1'b1;
      k = cyc + 1;
      exp_q.push_back({8'h77, 24'h030100, k + 4});
      step;
      fetch_req = 1'b0;
      wait_cyc(k + 4);
      total++;
      if (o_rom_timeout !== 1'b1) begin
         bad++;
         $display("FAIL timeout_held_at_rdy to=%b, want 1", o_rom_timeout);
      end
      step;
      total++;
      if (o_rom_timeout !== 1'b0) begin
         bad++;
         $display("FAIL timeout_clear to=%b after romrdy, want 0", o_rom_timeout);
      end
`else
      repeat (12) step;
      total++;
      if ({o_rom_timeout, o_busy, o_rom_rd_n} !== 3'b001) begin
         bad++;
         $display("FAIL no_owner_idle to=%b busy=%b rd_n=%b, want 0 0 1", o_rom_timeout, o_busy, o_rom_rd_n);
      end
      fetch_req = 1'b0;
`endif
      step;
      drain("timeout");
   endtask

   task automatic test_reset_mid;
      logic [31:0] k;
      clsr = 1'b1; ron = 1'b1; pbr = 8'h04; pc = 16'h4444; rom_data = 8'h99;
      step;
      k = cyc + 1; fetch_req = 1'b1;
      wait_cyc(k + 2);
      rst_n = 1'b0; fetch_req = 1'b0;
      #1;
      total++;
      if ({o_rom_rd_n, o_romrdy, o_instr_data, o_busy, o_rom_addr} !== {1'b1, 1'b0, 8'h00, 1'b0, 24'h0}) begin
         bad++;
         $display("FAIL reset_mid rd_n=%b rdy=%b data=%h busy=%b addr=%h, want 1 0 00 0 000000",
                  o_rom_rd_n, o_romrdy, o_instr_data, o_busy, o_rom_addr);
      end
      step;
      rst_n = 1'b1;
      repeat (8) step;
      drain("reset_mid");
   endtask

   initial begin
      test_reset;
      test_slow_fetch;
      test_clsr_back_to_back;
      test_ron_drop;
      test_branch;
      test_back_to_back;
      test_timeout;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
